// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master: in_valid,a,b,cin,sub,out_ready out; slave: in_ready,out_valid,sum,cout,ovf,zero out.
interface cla_pipe_addsub_if #(
   parameter int WIDTH = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead add/sub, one SW-bit slice per stage, valid/ready flow.
// Ports: clk, rst (sync, active high), io (slave): operands in, sum/cout/ovf/zero out.
module cla_pipe_addsub #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 3,
   parameter int BLOCK  = 4
) (
   input logic         clk,
   input logic         rst,
   cla_pipe_addsub_if.slave io
);
   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / BLOCK;
   localparam int L  = STAGES - 1;

   wire [STAGES-1:0] acc;

   assign io.in_ready = acc[0];

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      // ua/ub: operand bits from this slice upward (already skewed)
      localparam int UW = WIDTH - s * SW;
      localparam int LW = (s + 1) * SW;

      logic [UW-1:0] ua;
      logic [UW-1:0] ub;
      logic          ci;
      logic          vi;
      logic [SW-1:0] sl_sum;
      logic [SW:0]   sl_c;
      logic [LW-1:0] sum_n;
      logic [LW-1:0] sum_q;
      logic          c_q;
      logic          v_q;

      if (s == 0) begin : g_in
         assign ua    = io.a;
         assign ub    = io.b ^ {WIDTH{io.sub}};
         assign ci    = io.cin ^ io.sub;
         assign vi    = io.in_valid;
         assign sum_n = sl_sum;
      end else begin : g_in
         assign ua    = g_st[s-1].g_fwd.a_q;
         assign ub    = g_st[s-1].g_fwd.b_q;
         assign ci    = g_st[s-1].c_q;
         assign vi    = g_st[s-1].v_q;
         assign sum_n = {sl_sum, g_st[s-1].sum_q};
      end

      if (s == L) begin : g_acc
         assign acc[s] = !v_q | io.out_ready;
      end else begin : g_acc
         assign acc[s] = !v_q | acc[s+1];
      end

      // Two-level g/p inside each BLOCK group; group carries ripple.
      always_comb begin
         logic [SW-1:0] g;
         logic [SW-1:0] p;
         logic [SW:0]   c;
         logic          t;
         logic          pr;
         g    = ua[SW-1:0] & ub[SW-1:0];
         p    = ua[SW-1:0] ^ ub[SW-1:0];
         c    = '0;
         c[0] = ci;
         t    = 1'b0;
         pr   = 1'b1;
         for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < BLOCK; k++) begin
               t  = g[j*BLOCK+k];
               pr = p[j*BLOCK+k];
               for (int m = k - 1; m >= 0; m--) begin
                  t  = t | (pr & g[j*BLOCK+m]);
                  pr = pr & p[j*BLOCK+m];
               end
               c[j*BLOCK+k+1] = t | (pr & c[j*BLOCK]);
            end
         end
         sl_c   = c;
         sl_sum = p ^ c[SW-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (acc[s]) begin
            v_q   <= vi;
            c_q   <= sl_c[SW];
            sum_q <= sum_n;
         end
      end

      if (s < L) begin : g_fwd
         logic [UW-SW-1:0] a_q;
         logic [UW-SW-1:0] b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (acc[s]) begin
               a_q <= ua[UW-1:SW];
               b_q <= ub[UW-1:SW];
            end
         end
      end else begin : g_out
         // c_(WIDTH-1) and zero are registered so outputs are pure flops
         logic cm_q;
         logic z_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               cm_q <= 1'b0;
               z_q  <= 1'b0;
            end else if (acc[s]) begin
               cm_q <= sl_c[SW-1];
               z_q  <= (sum_n == '0);
            end
         end

         assign io.sum       = sum_q;
         assign io.cout      = c_q;
         assign io.ovf       = c_q ^ cm_q;
         assign io.zero      = z_q;
         assign io.out_valid = v_q;
      end
   end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's fixed-width combinational CLA.
- The operand width is split into STAGES slices. Each slice is built from BLOCK-bit lookahead groups, and the carry is registered between slices.
- A valid/ready handshake provides back-pressure. Status flags are carry/borrow, signed overflow and zero.
- The block sits between the operand-issue logic and any result consumer on the datapath.

Parameters:
- WIDTH, 12, operand/result width. Must be divisible by STAGES.
- STAGES, 3, number of pipeline slices and register stages (1..WIDTH). Slice width SW = WIDTH/STAGES. SW must be divisible by BLOCK.
- BLOCK, 4, lookahead group size inside a slice. Carries within a group come from two-level generate/propagate. Groups ripple their group carry.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result
- cout  output  1  carry-out; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

Behaviour:
- Arithmetic:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - sub=0 gives a+b+cin. sub=1 gives a-b-cin.
  - Per bit: g = a & b_eff, p = a ^ b_eff, sum_i = p_i ^ c_i.
  - cout = c_WIDTH.
  - ovf = c_WIDTH ^ c_(WIDTH-1).
  - zero = (sum == 0).
- Pipeline structure:
  - Stage s (0..STAGES-1) computes slice bits [s*SW +: SW] combinationally from the carry registered by stage s-1 (stage 0 uses c0).
  - Stage s registers: its slice result, all lower result slices, the upper operand slices (a and b_eff skewed), its carry-out, c_(WIDTH-1) in the last stage, and a valid bit v[s].
  - sum/cout/ovf/zero/out_valid are driven directly from the last-stage registers; there is no combinational path from a/b to outputs.
- Handshake:
  - accept[last] = !v[last] | out_ready.
  - accept[s] = !v[s] | accept[s+1].
  - in_ready = accept[0] (combinational from out_ready and v[]).
  - Stage s loads when accept[s]. It loads valid data if the upstream stage holds valid data (or in_valid for s=0); otherwise it loads a bubble, v[s]=0.
  - Bubbles collapse. Full throughput is one result per cycle while out_ready=1.
- Latency: an operand pair accepted on edge E appears with out_valid=1 after edge E+STAGES-1 when there is no stall (3 edges total at default).
- Stall: while out_ready=0 and out_valid=1, the output registers hold stable (sum, flags unchanged). Upstream stages fill; in_ready drops once all STAGES stages are valid.
- Transfer: a transfer occurs on any edge with out_valid & out_ready. Each accepted input produces exactly one output, in order, with no duplication or loss.
- Simultaneous events:
  - When full with out_ready=1 and in_valid=1, the output retires and a new input enters on the same edge.
  - When in_valid=0 while draining, bubbles enter.
- Reset:
  - rst=1 clears all v[] and drives sum=0, cout=0, ovf=0, zero=0, out_valid=0. Data registers may also be cleared.
  - in_ready=1 during the reset cycle's output evaluation after reset (v all 0).
  - Reset mid-operation discards all in-flight results; none appear afterwards.
- STAGES=1: single register stage, latency 1 edge.

Test Plan:
- Default params, add a=0x7FF b=0x001 cin=0 sub=0 -> after 3 edges sum=0x800, cout=0, ovf=1, zero=0.
- Add a=0xFFF b=0x001 cin=0 -> sum=0x000, cout=1, ovf=0, zero=1. Add a=0x0A5 b=0x05A cin=1 -> sum=0x100, cout=0.
- Sub a=0x005 b=0x007 cin=0 -> sum=0xFFE, cout=0, ovf=0. Sub a=0x800 b=0x001 -> sum=0x7FF, cout=1, ovf=1. Sub a=0x010 b=0x010 cin=1 -> sum=0xFFF, cout=0.
- Stream 8 back-to-back random pairs with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model a±b±cin.
- Stall: stream 5 inputs, hold out_ready=0 from cycle 2 for 6 cycles -> in_ready low once 3 stages are valid, outputs frozen, then all 5 results delivered in order with no loss.
- Assert rst for 1 cycle with 2 results in flight -> out_valid=0 and outputs zero next cycle, no stale result emitted. Repeat the add vectors at WIDTH=32, STAGES=4, BLOCK=4 and WIDTH=8, STAGES=1 against the model.
